tinyrisc_v_soc: RTL and testbench
=================================

Name: tinyrisc_v_soc

Overview:
Minimal RV32I system-on-chip: a single-cycle core (u_tinyrisc_v), an instruction ROM (u_rom) and a data RAM (u_ram). It runs riscv-tests style programs preloaded into the ROM. Only clock and reset are external; results are inspected hierarchically through the register file u_tinyrisc_v.u_regs.regs_memb[0:31].

Parameters:
ROM_DEPTH, 4096, instruction ROM depth in 32-bit words (u_rom.rom_memb[0:ROM_DEPTH-1], preloadable by $readmemh).
RAM_DEPTH, 4096, data RAM depth in 32-bit words.
RESET_PC, 32'h0000_0000, PC value on reset.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, asynchronous and active-high.

Behaviour:
- Reset (rst=1, asynchronous): PC=RESET_PC; all 32 registers regs_memb[*]=0; RAM contents are not cleared; ROM is never written. The first instruction executes on the first rising clk after rst deasserts.
- Single-cycle execution: one instruction per clk.
  - Instruction fetch: ROM is read combinationally at rom_memb[pc[31:2]], and address bits beyond ROM_DEPTH wrap.
  - Register write and PC update occur on the same rising edge.
- Register file: 32x32. x0 always reads 0, and writes to x0 are ignored. The file has two combinational read ports and one synchronous write port.
- Supported instructions, per the RV32I spec:
  - LUI, AUIPC (rd = pc + {imm[31:12], 12'b0}), JAL, JALR (target LSB cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
  - LB, LH, LW, LBU, LHU, SB, SH, SW.
- Arithmetic: 32-bit modulo 2^32, no overflow traps.
  - Shift amount is rs2[4:0] or imm[4:0].
  - SRA/SRAI are arithmetic shifts; SLT compares signed, SLTU unsigned.
- Branch/jump targets are pc + sign-extended immediate. JAL/JALR write pc+4 to rd, and the write happens even when rd equals rs1 for JALR, using the old rs1 value. Otherwise next PC = pc+4.
- Data RAM:
  - Byte-addressed with little-endian lanes and word index addr[31:2] (wraps).
  - Loads are combinational; byte/halfword loads are sign- or zero-extended per the opcode.
  - Stores are synchronous with byte enables; SB/SH write only the addressed lanes.
  - Misaligned halfword/word accesses use the addressed word with addr[1:0] masked.
- FENCE, FENCE.I, ECALL, EBREAK, CSR* and any unrecognised opcode execute as NOP (pc+4, no write). The CSR rd destination is not written.
- Test-harness convention (software-defined): the program writes x26=1 at test end; x27=1 means pass; x3 holds the failing test number.
- Reset mid-execution: PC and registers clear immediately; any in-flight store in that cycle is discarded.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release → PC=0 and all regs_memb=0 before the first edge; the first instruction fetched is rom_memb[0].
- AUIPC/LUI: ROM at word 0 = auipc x5,0x1 and word 1 = lui x6,0xABCDE → x5=32'h0000_1000, x6=32'hABCD_E000 after 2 cycles.
- ALU/x0: addi x1,x0,-1; srai x2,x1,4; srli x3,x1,28; sltu x4,x0,x1; addi x0,x0,5 → x1=FFFF_FFFF, x2=FFFF_FFFF, x3=0000_000F, x4=1, x0=0.
- Branch/jump: bne not taken then taken, jal x1,+8, jalr x0,0(x1) → PC sequence matches the RV32I spec; x1 = address of the jal + 4.
- Load/store: sw 0x8000_00FF at addr 0x100; lb x7,0x100; lbu x8,0x100; sh 0x1234 at 0x102; lw x9,0x100 → x7=FFFF_FFFF, x8=0000_00FF, x9=1234_00FF.
- riscv-tests run: load rv32ui-p-auipc image → x26 becomes 1 and, 2 cycles later, x27=1 (pass); repeat for rv32ui-p-add, beq and lw.

Source files
------------

// File: rtl/tinyrisc_v_soc.sv
// tinyrisc_v_soc: single-cycle RV32I core with instruction ROM and data RAM.
// The ROM is filled through its load port or by direct preload of rom_memb.

module tinyrisc_v_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] regs_memb [0:31];

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_memb[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_memb[raddr2];

  // clear all registers on reset, single write port, x0 stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) regs_memb[r] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs_memb[waddr] <= wdata;
    end
  end
endmodule

module tinyrisc_v_rom #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic [31:0]              addr,
  output logic [31:0]              data
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   rom_memb [0:DEPTH-1];
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign idx         = addr[AW+1:2];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign data        = rom_memb[idx];

  // image load port; the running core never writes here
  always_ff @(posedge clk) begin
    if (load_en) rom_memb[load_addr] <= load_data;
  end
endmodule

module tinyrisc_v_ram #(
  parameter int DEPTH = 4096
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   ram_memb [0:DEPTH-1];
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign idx         = addr[AW+1:2];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign rdata       = ram_memb[idx];

  // byte-lane store; contents survive reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) ram_memb[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end
endmodule

module tinyrisc_v #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);
  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, rd_val;
  logic        rd_we, st_en;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_opimm, is_op;

  logic [31:0] alu_b, alu_res, sra_res, addr_i;
  logic [4:0]  shamt;
  logic        op_ok, opimm_ok;
  logic        br_ok, br_take, eq, lt_s, lt_u;
  logic        ld_ok, st_ok;
  logic [31:0] ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign imem_addr = pc;
  assign instr     = imem_data;
  assign pc_plus4  = pc + 32'd4;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  assign is_lui    = opcode == 7'b0110111;
  assign is_auipc  = opcode == 7'b0010111;
  assign is_jal    = opcode == 7'b1101111;
  assign is_jalr   = opcode == 7'b1100111;
  assign is_branch = opcode == 7'b1100011;
  assign is_load   = opcode == 7'b0000011;
  assign is_store  = opcode == 7'b0100011;
  assign is_opimm  = opcode == 7'b0010011;
  assign is_op     = opcode == 7'b0110011;

  tinyrisc_v_regs u_regs (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .we     (rd_we),
    .waddr  (rd),
    .wdata  (rd_val)
  );

  assign addr_i    = rs1_val + imm_i;
  assign dmem_addr = is_store ? rs1_val + imm_s : addr_i;
  assign dmem_we   = st_en & ~rst;

  assign op_ok = (funct7 == 7'h00) ||
                 (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
  assign opimm_ok = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                    (funct3 == 3'b101) ? (funct7 == 7'h00 || funct7 == 7'h20) :
                    1'b1;

  // shared ALU for register and immediate forms
  always_comb begin
    alu_b   = is_op ? rs2_val : imm_i;
    shamt   = alu_b[4:0];
    sra_res = $signed(rs1_val) >>> shamt;
    unique case (funct3)
      3'b000: alu_res = (is_op && instr[30]) ? rs1_val - alu_b
                                             : rs1_val + alu_b;
      3'b001: alu_res = rs1_val << shamt;
      3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_res = {31'b0, rs1_val < alu_b};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: alu_res = instr[30] ? sra_res : rs1_val >> shamt;
      3'b110: alu_res = rs1_val | alu_b;
      3'b111: alu_res = rs1_val & alu_b;
    endcase
  end

  assign eq   = rs1_val == rs2_val;
  assign lt_s = $signed(rs1_val) < $signed(rs2_val);
  assign lt_u = rs1_val < rs2_val;

  // branch condition select
  always_comb begin
    br_ok   = 1'b1;
    br_take = 1'b0;
    unique case (funct3)
      3'b000:  br_take = eq;
      3'b001:  br_take = ~eq;
      3'b100:  br_take = lt_s;
      3'b101:  br_take = ~lt_s;
      3'b110:  br_take = lt_u;
      3'b111:  br_take = ~lt_u;
      default: br_ok   = 1'b0;
    endcase
  end

  // load lane pick and extension
  always_comb begin
    ld_ok  = 1'b1;
    ld_val = '0;
    unique case (dmem_addr[1:0])
      2'b00: ld_byte = dmem_rdata[7:0];
      2'b01: ld_byte = dmem_rdata[15:8];
      2'b10: ld_byte = dmem_rdata[23:16];
      2'b11: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = dmem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_val = dmem_rdata;
      3'b100:  ld_val = {24'b0, ld_byte};
      3'b101:  ld_val = {16'b0, ld_half};
      default: ld_ok  = 1'b0;
    endcase
  end

  // store lane replication and byte enables
  always_comb begin
    st_ok      = 1'b1;
    dmem_be    = '0;
    dmem_wdata = rs2_val;
    unique case (funct3)
      3'b000: begin
        dmem_wdata = {4{rs2_val[7:0]}};
        dmem_be    = 4'b0001 << dmem_addr[1:0];
      end
      3'b001: begin
        dmem_wdata = {2{rs2_val[15:0]}};
        dmem_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010:  dmem_be = 4'b1111;
      default: st_ok   = 1'b0;
    endcase
  end

  // main decode: writeback, next pc, store enable
  always_comb begin
    pc_next = pc_plus4;
    rd_we   = 1'b0;
    rd_val  = '0;
    st_en   = 1'b0;
    unique case (1'b1)
      is_lui: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      is_auipc: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      is_jal: begin
        rd_we   = 1'b1;
        rd_val  = pc_plus4;
        pc_next = pc + imm_j;
      end
      is_jalr: begin
        if (funct3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_val  = pc_plus4;
          pc_next = addr_i & ~32'h1;
        end
      end
      is_branch: begin
        if (br_ok && br_take) pc_next = pc + imm_b;
      end
      is_load: begin
        rd_we  = ld_ok;
        rd_val = ld_val;
      end
      is_store: st_en = st_ok;
      is_opimm: begin
        rd_we  = opimm_ok;
        rd_val = alu_res;
      end
      is_op: begin
        rd_we  = op_ok;
        rd_val = alu_res;
      end
      default: ;
    endcase
  end

  // program counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end
endmodule

module tinyrisc_v_soc #(
  parameter int          ROM_DEPTH = 4096,
  parameter int          RAM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  logic [31:0] imem_addr, imem_data;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;
  logic [3:0]  dmem_be;

  tinyrisc_v #(.RESET_PC(RESET_PC)) u_tinyrisc_v (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_we    (dmem_we),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  tinyrisc_v_rom #(.DEPTH(ROM_DEPTH)) u_rom (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data ('0),
    .addr      (imem_addr),
    .data      (imem_data)
  );

  tinyrisc_v_ram #(.DEPTH(RAM_DEPTH)) u_ram (
    .clk   (clk),
    .addr  (dmem_addr),
    .we    (dmem_we),
    .be    (dmem_be),
    .wdata (dmem_wdata),
    .rdata (dmem_rdata)
  );
endmodule

// File: tb/tb_tinyrisc_v_soc.sv
// tb_tinyrisc_v_soc: directed programs preloaded into the ROM,
// results read from the register file, PC and RAM.

module tb_tinyrisc_v_soc;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] prog [0:31];

  tinyrisc_v_soc dut (.clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] xr(input int r);
    return dut.u_tinyrisc_v.u_regs.regs_memb[r];
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd,
    input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] r_t(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] s_t(input logic [11:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(input logic [12:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] u_t(input logic [19:0] imm,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] j_t(input logic [20:0] imm,
    input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic load(input int n);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++)
      dut.u_rom.rom_memb[i] = (i < n) ? prog[i] : NOP;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic any;
    prog[0] = addi(5'd1, 5'd0, 12'd7);
    prog[1] = addi(5'd2, 5'd1, 12'd1);
    load(2);
    run(3);
    n_cmp++;
    if (xr(2) !== 32'd8) begin
      n_bad++;
      $display("FAIL reset_pre x2: got %h want %h", xr(2), 32'd8);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dut.u_tinyrisc_v.pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_pc: got %h want %h", dut.u_tinyrisc_v.pc, 32'h0);
    end
    any = 1'b0;
    for (int r = 0; r < 32; r++) if (xr(r) !== 32'h0) any = 1'b1;
    n_cmp++;
    if (any !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_regs: got nonzero=%b want nonzero=0", any);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (dut.u_tinyrisc_v.instr !== prog[0]) begin
      n_bad++;
      $display("FAIL first_fetch: got %h want %h",
               dut.u_tinyrisc_v.instr, prog[0]);
    end
    run(1);
    n_cmp++;
    if (xr(1) !== 32'd7 || dut.u_tinyrisc_v.pc !== 32'd4) begin
      n_bad++;
      $display("FAIL first_exec: got x1=%h pc=%h want x1=%h pc=%h",
               xr(1), dut.u_tinyrisc_v.pc, 32'd7, 32'd4);
    end
  endtask

  task automatic test_upper;
    prog[0] = u_t(20'h00001, 5'd5, 7'h17);
    prog[1] = u_t(20'hABCDE, 5'd6, 7'h37);
    prog[2] = u_t(20'hFFFFF, 5'd7, 7'h17);
    load(3);
    run(2);
    n_cmp++;
    if (xr(5) !== 32'h0000_1000 || xr(6) !== 32'hABCD_E000) begin
      n_bad++;
      $display("FAIL upper: got x5=%h x6=%h want x5=%h x6=%h",
               xr(5), xr(6), 32'h0000_1000, 32'hABCD_E000);
    end
    run(1);
    n_cmp++;
    if (xr(7) !== 32'hFFFF_F008) begin
      n_bad++;
      $display("FAIL auipc_neg: got %h want %h", xr(7), 32'hFFFF_F008);
    end
  endtask

  task automatic test_alu;
    int          ar [21] = '{1, 2, 3, 4, 0, 10, 11, 12, 13, 14, 15,
                             16, 17, 18, 19, 20, 21, 22, 23, 24, 5};
    logic [31:0] av [21] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F,
                             32'h1, 32'h0, 32'h5, 32'h6, 32'h1, 32'h0,
                             32'hFFFF_FFFA, 32'h0000_00A0, 32'hFFFF_FFFF,
                             32'h07FF_FFFF, 32'h1, 32'h0000_07F0, 32'h7,
                             32'h4, 32'h4, 32'h4000_0000, 32'hFFFF_F800,
                             32'h0};
    prog[0]  = addi(5'd1, 5'd0, 12'hFFF);
    prog[1]  = i_t(12'h404, 5'd1, 3'b101, 5'd2, 7'h13);
    prog[2]  = i_t(12'h01C, 5'd1, 3'b101, 5'd3, 7'h13);
    prog[3]  = r_t(7'h00, 5'd1, 5'd0, 3'b011, 5'd4);
    prog[4]  = addi(5'd0, 5'd0, 12'd5);
    prog[5]  = addi(5'd10, 5'd0, 12'd5);
    prog[6]  = r_t(7'h20, 5'd1, 5'd10, 3'b000, 5'd11);
    prog[7]  = r_t(7'h00, 5'd10, 5'd1, 3'b010, 5'd12);
    prog[8]  = r_t(7'h00, 5'd10, 5'd1, 3'b011, 5'd13);
    prog[9]  = i_t(12'hFFF, 5'd10, 3'b100, 5'd14, 7'h13);
    prog[10] = r_t(7'h00, 5'd10, 5'd10, 3'b001, 5'd15);
    prog[11] = r_t(7'h20, 5'd10, 5'd1, 3'b101, 5'd16);
    prog[12] = r_t(7'h00, 5'd10, 5'd1, 3'b101, 5'd17);
    prog[13] = i_t(12'h000, 5'd1, 3'b010, 5'd18, 7'h13);
    prog[14] = i_t(12'h7F0, 5'd1, 3'b111, 5'd19, 7'h13);
    prog[15] = r_t(7'h00, 5'd11, 5'd10, 3'b110, 5'd20);
    prog[16] = r_t(7'h00, 5'd11, 5'd10, 3'b111, 5'd21);
    prog[17] = r_t(7'h00, 5'd10, 5'd1, 3'b000, 5'd22);
    prog[18] = i_t(12'h01E, 5'd10, 3'b001, 5'd23, 7'h13);
    prog[19] = i_t(12'h800, 5'd0, 3'b110, 5'd24, 7'h13);
    prog[20] = r_t(7'h01, 5'd10, 5'd10, 3'b000, 5'd5);
    load(21);
    run(21);
    for (int i = 0; i < 21; i++) begin
      n_cmp++;
      if (xr(ar[i]) !== av[i]) begin
        n_bad++;
        $display("FAIL alu x%0d: got %h want %h", ar[i], xr(ar[i]), av[i]);
      end
    end
  endtask

  task automatic test_branch_jump;
    logic [31:0] seq [6] = '{32'd4, 32'd8, 32'd16, 32'd24, 32'd20, 32'd24};
    prog[0] = addi(5'd5, 5'd0, 12'd1);
    prog[1] = b_t(13'd8, 5'd5, 5'd5, 3'b001);
    prog[2] = b_t(13'd8, 5'd0, 5'd5, 3'b001);
    prog[3] = addi(5'd6, 5'd0, 12'd1);
    prog[4] = j_t(21'd8, 5'd1);
    prog[5] = addi(5'd7, 5'd0, 12'd1);
    prog[6] = i_t(12'h000, 5'd1, 3'b000, 5'd0, 7'h67);
    load(7);
    for (int i = 0; i < 6; i++) begin
      run(1);
      n_cmp++;
      if (dut.u_tinyrisc_v.pc !== seq[i]) begin
        n_bad++;
        $display("FAIL bj_pc step %0d: got %h want %h",
                 i, dut.u_tinyrisc_v.pc, seq[i]);
      end
    end
    n_cmp++;
    if (xr(1) !== 32'd20 || xr(6) !== 32'd0 || xr(7) !== 32'd1) begin
      n_bad++;
      $display("FAIL bj_regs: got x1=%h x6=%h x7=%h want 14 0 1",
               xr(1), xr(6), xr(7));
    end
  endtask

  task automatic test_branch_cmp;
    logic [31:0] seq [6] = '{32'd4, 32'd12, 32'd16, 32'd24, 32'd32, 32'd0};
    prog[0] = addi(5'd1, 5'd0, 12'hFFF);
    prog[1] = b_t(13'd8, 5'd0, 5'd1, 3'b100);
    prog[2] = addi(5'd2, 5'd0, 12'd1);
    prog[3] = b_t(13'd8, 5'd0, 5'd1, 3'b110);
    prog[4] = b_t(13'd8, 5'd0, 5'd1, 3'b111);
    prog[5] = addi(5'd3, 5'd0, 12'd1);
    prog[6] = b_t(13'd8, 5'd1, 5'd0, 3'b101);
    prog[7] = addi(5'd4, 5'd0, 12'd1);
    prog[8] = b_t(13'h1FE0, 5'd0, 5'd0, 3'b000);
    load(9);
    for (int i = 0; i < 6; i++) begin
      run(1);
      n_cmp++;
      if (dut.u_tinyrisc_v.pc !== seq[i]) begin
        n_bad++;
        $display("FAIL bcmp_pc step %0d: got %h want %h",
                 i, dut.u_tinyrisc_v.pc, seq[i]);
      end
    end
    n_cmp++;
    if ((xr(2) | xr(3) | xr(4)) !== 32'd0) begin
      n_bad++;
      $display("FAIL bcmp_skip: got x2=%h x3=%h x4=%h want 0 0 0",
               xr(2), xr(3), xr(4));
    end
  endtask

  task automatic test_jalr_same_reg;
    prog[0] = addi(5'd5, 5'd0, 12'd12);
    prog[1] = i_t(12'h001, 5'd5, 3'b000, 5'd5, 7'h67);
    prog[2] = addi(5'd6, 5'd0, 12'd1);
    prog[3] = addi(5'd7, 5'd5, 12'd0);
    load(4);
    run(2);
    n_cmp++;
    if (dut.u_tinyrisc_v.pc !== 32'd12 || xr(5) !== 32'd8) begin
      n_bad++;
      $display("FAIL jalr_rd_rs1: got pc=%h x5=%h want pc=%h x5=%h",
               dut.u_tinyrisc_v.pc, xr(5), 32'd12, 32'd8);
    end
    run(1);
    n_cmp++;
    if (xr(7) !== 32'd8 || xr(6) !== 32'd0) begin
      n_bad++;
      $display("FAIL jalr_after: got x7=%h x6=%h want 8 0", xr(7), xr(6));
    end
  endtask

  task automatic test_load_store;
    int          ar [11] = '{7, 8, 9, 10, 12, 13, 14, 15, 16, 17, 3};
    logic [31:0] av [11] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h1234_00FF,
                             32'h0000_1234, 32'h0000_0012, 32'hFFFF_FFFF,
                             32'h0000_FFFF, 32'h1234_FFFF, 32'h1234_FFFF,
                             32'h1234_FFFF, 32'h0000_1234};
    prog[0]  = u_t(20'h80000, 5'd1, 7'h37);
    prog[1]  = addi(5'd1, 5'd1, 12'h0FF);
    prog[2]  = addi(5'd2, 5'd0, 12'h100);
    prog[3]  = s_t(12'h000, 5'd1, 5'd2, 3'b010);
    prog[4]  = i_t(12'h000, 5'd2, 3'b000, 5'd7, 7'h03);
    prog[5]  = i_t(12'h000, 5'd2, 3'b100, 5'd8, 7'h03);
    prog[6]  = u_t(20'h00001, 5'd3, 7'h37);
    prog[7]  = addi(5'd3, 5'd3, 12'h234);
    prog[8]  = s_t(12'h002, 5'd3, 5'd2, 3'b001);
    prog[9]  = i_t(12'h000, 5'd2, 3'b010, 5'd9, 7'h03);
    prog[10] = i_t(12'h002, 5'd2, 3'b001, 5'd10, 7'h03);
    prog[11] = i_t(12'h003, 5'd2, 3'b000, 5'd12, 7'h03);
    prog[12] = s_t(12'h001, 5'd1, 5'd2, 3'b000);
    prog[13] = i_t(12'h000, 5'd2, 3'b001, 5'd13, 7'h03);
    prog[14] = i_t(12'h000, 5'd2, 3'b101, 5'd14, 7'h03);
    prog[15] = i_t(12'h000, 5'd2, 3'b010, 5'd15, 7'h03);
    prog[16] = i_t(12'h001, 5'd2, 3'b010, 5'd16, 7'h03);
    prog[17] = u_t(20'h00004, 5'd18, 7'h37);
    prog[18] = addi(5'd18, 5'd18, 12'h100);
    prog[19] = i_t(12'h000, 5'd18, 3'b010, 5'd17, 7'h03);
    load(20);
    run(20);
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (xr(ar[i]) !== av[i]) begin
        n_bad++;
        $display("FAIL ldst x%0d: got %h want %h", ar[i], xr(ar[i]), av[i]);
      end
    end
    n_cmp++;
    if (dut.u_ram.ram_memb[64] !== 32'h1234_FFFF) begin
      n_bad++;
      $display("FAIL ldst_ram: got %h want %h",
               dut.u_ram.ram_memb[64], 32'h1234_FFFF);
    end
  endtask

  task automatic test_nop_ops;
    prog[0] = addi(5'd5, 5'd0, 12'd3);
    prog[1] = {12'h300, 5'd1, 3'b001, 5'd5, 7'h73};
    prog[2] = 32'h0000_0073;
    prog[3] = 32'h0000_000F;
    prog[4] = 32'hFFFF_FFFF;
    prog[5] = b_t(13'd8, 5'd0, 5'd0, 3'b010);
    prog[6] = addi(5'd6, 5'd0, 12'd9);
    load(7);
    run(7);
    n_cmp++;
    if (xr(5) !== 32'd3 || xr(6) !== 32'd9 ||
        dut.u_tinyrisc_v.pc !== 32'd28) begin
      n_bad++;
      $display("FAIL nop_ops: got x5=%h x6=%h pc=%h want 3 9 1c",
               xr(5), xr(6), dut.u_tinyrisc_v.pc);
    end
  endtask

  task automatic test_mid_reset;
    prog[0] = addi(5'd1, 5'd0, 12'h055);
    prog[1] = addi(5'd2, 5'd0, 12'h200);
    prog[2] = s_t(12'h000, 5'd1, 5'd2, 3'b010);
    prog[3] = j_t(21'd0, 5'd0);
    load(4);
    dut.u_ram.ram_memb[128] = 32'hDEAD_BEEF;
    run(2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dut.u_tinyrisc_v.pc !== 32'd0 || xr(1) !== 32'd0) begin
      n_bad++;
      $display("FAIL midrst_async: got pc=%h x1=%h want 0 0",
               dut.u_tinyrisc_v.pc, xr(1));
    end
    run(1);
    n_cmp++;
    if (dut.u_ram.ram_memb[128] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL midrst_store: got %h want %h",
               dut.u_ram.ram_memb[128], 32'hDEAD_BEEF);
    end
    @(negedge clk);
    rst = 1'b0;
    run(3);
    n_cmp++;
    if (dut.u_ram.ram_memb[128] !== 32'h0000_0055) begin
      n_bad++;
      $display("FAIL midrst_resume: got %h want %h",
               dut.u_ram.ram_memb[128], 32'h0000_0055);
    end
  endtask

  task automatic test_harness;
    int cyc;
    prog[0]  = addi(5'd3, 5'd0, 12'd1);
    prog[1]  = addi(5'd10, 5'd0, 12'd7);
    prog[2]  = addi(5'd11, 5'd0, 12'hFFD);
    prog[3]  = r_t(7'h00, 5'd11, 5'd10, 3'b000, 5'd12);
    prog[4]  = addi(5'd13, 5'd0, 12'd4);
    prog[5]  = b_t(13'd56, 5'd13, 5'd12, 3'b001);
    prog[6]  = addi(5'd3, 5'd0, 12'd2);
    prog[7]  = u_t(20'h00000, 5'd14, 7'h17);
    prog[8]  = addi(5'd15, 5'd0, 12'h01C);
    prog[9]  = b_t(13'd40, 5'd15, 5'd14, 3'b001);
    prog[10] = addi(5'd3, 5'd0, 12'd3);
    prog[11] = s_t(12'h040, 5'd12, 5'd0, 3'b010);
    prog[12] = i_t(12'h040, 5'd0, 3'b010, 5'd16, 7'h03);
    prog[13] = b_t(13'd8, 5'd13, 5'd16, 3'b000);
    prog[14] = j_t(21'd20, 5'd0);
    prog[15] = addi(5'd26, 5'd0, 12'd1);
    prog[16] = NOP;
    prog[17] = addi(5'd27, 5'd0, 12'd1);
    prog[18] = j_t(21'd0, 5'd0);
    prog[19] = addi(5'd26, 5'd0, 12'd1);
    prog[20] = NOP;
    prog[21] = addi(5'd27, 5'd0, 12'd2);
    prog[22] = j_t(21'd0, 5'd0);
    load(23);
    cyc = 0;
    while (xr(26) !== 32'd1 && cyc < 200) begin
      run(1);
      cyc++;
    end
    n_cmp++;
    if (cyc >= 200) begin
      n_bad++;
      $display("FAIL harness_done: got timeout after %0d cycles want x26=1",
               cyc);
    end
    run(2);
    n_cmp++;
    if (xr(27) !== 32'd1 || xr(3) !== 32'd3) begin
      n_bad++;
      $display("FAIL harness_pass: got x27=%h x3=%h want 1 3",
               xr(27), xr(3));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int i = 0; i < 4096; i++) dut.u_rom.rom_memb[i] = NOP;
    test_reset();
    test_upper();
    test_alu();
    test_branch_jump();
    test_branch_cmp();
    test_jalr_same_reg();
    test_load_store();
    test_nop_ops();
    test_mid_reset();
    test_harness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
